// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - boot byte stream and instruction memory bus bundle
//
// Ports (signals):
//   rx_data   [7:0]            boot byte from the source
//   rx_valid                   rx_data valid
//   rx_ready                   loader accepts rx_data this cycle
//   pc        [INST_WIDTH-1:0] CPU fetch address
//   mem_we                     byte write strobe to instruction memory
//   mem_addr  [ADDR_WIDTH-1:0] memory byte address
//   mem_wdata [7:0]            byte to write
// Modports: master = byte source / CPU / memory side, slave = loader.
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int INST_WIDTH = 32
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [INST_WIDTH-1:0] pc;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;

    modport master (
        output rx_data, rx_valid, pc,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_data, rx_valid, pc,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a length/payload/XOR-checksum frame into instruction memory
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-low reset
//   start      one-cycle request to begin a load (honoured in IDLE, RUN, ERROR)
//   bus        imem_boot_loader_if.slave: rx byte stream, CPU pc, memory write port
//   cpu_rst_n  CPU reset, released only while a valid image is running
//   busy       load in progress
//   done       image valid, CPU running
//   error      load failed, held until the next start
//   byte_count payload bytes written in the current load
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int INST_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    imem_boot_loader_if.slave     bus,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   byte_count
);
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, CHECK, RUN, ERROR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

    state_t                state_q;
    state_t                state_nxt;
    logic [15:0]           length_q;
    logic [7:0]            acc_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [7:0]            wr_data_q;

    logic                  rx_ready;
    logic                  xfer;
    logic                  load_req;
    logic [15:0]           len_rx;
    logic                  len_ok;
    logic                  last_byte;
    logic                  unused_pc;

    assign rx_ready  = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA)   || (state_q == CHECK);
    assign xfer      = bus.rx_valid && rx_ready;
    assign load_req  = start && ((state_q == IDLE) || (state_q == RUN) || (state_q == ERROR));

    // Full length as it will be once the high byte lands this cycle.
    assign len_rx    = {bus.rx_data, length_q[7:0]};
    assign len_ok    = (len_rx != 16'd0) && ({1'b0, len_rx} <= MAX_LEN) && (len_rx[1:0] == 2'b00);
    assign last_byte = (16'(byte_count) + 16'd1) == length_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE, RUN, ERROR: if (start) state_nxt = LEN_LO;
            LEN_LO:           if (xfer) state_nxt = LEN_HI;
            LEN_HI:           if (xfer) state_nxt = len_ok ? DATA : ERROR;
            DATA:             if (xfer && last_byte) state_nxt = CHECK;
            CHECK:            if (xfer) state_nxt = (bus.rx_data == acc_q) ? RUN : ERROR;
            default:          state_nxt = IDLE;
        endcase
    end

    // byte_count doubles as the write pointer; the length check keeps it
    // below 2**ADDR_WIDTH for every byte actually written.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            length_q   <= '0;
            acc_q      <= '0;
            byte_count <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (load_req) begin
                length_q   <= '0;
                acc_q      <= '0;
                byte_count <= '0;
            end
            if (xfer) begin
                case (state_q)
                    LEN_LO: length_q[7:0]  <= bus.rx_data;
                    LEN_HI: length_q[15:8] <= bus.rx_data;
                    DATA: begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= byte_count[ADDR_WIDTH-1:0];
                        wr_data_q  <= bus.rx_data;
                        byte_count <= byte_count + (ADDR_WIDTH+1)'(1);
                        acc_q      <= acc_q ^ bus.rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.mem_we    = wr_en_q;
    assign bus.mem_wdata = wr_data_q;
    // Fetch path is the only combinational output: the CPU sees its own pc while running.
    assign bus.mem_addr  = ((state_q == RUN) && !wr_en_q) ? bus.pc[ADDR_WIDTH-1:0] : wr_addr_q;

    assign busy      = rx_ready;
    assign done      = (state_q == RUN);
    assign cpu_rst_n = (state_q == RUN);
    assign error     = (state_q == ERROR);

    assign unused_pc = ^bus.pc[INST_WIDTH-1:ADDR_WIDTH];
endmodule
